tff_bank_ctrl: RTL and testbench

- Sequencer for an external bank of WIDTH toggle flip-flops. Each flip-flop has an active-high async clear, a toggle enable and a q output.
- Drives the bank's per-bit toggle enables and a shared clear so the bank acts as a clearable, loadable, up/down counter that stops at a programmable limit.
- Commands arrive on a valid/ready handshake. Bank state is read back on q_in, so the controller holds no copy of the count.

---
 rtl/tff_bank_ctrl.sv | 99 +++++++++
 tb/tb_tff_bank_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_ctrl.sv
// Sequencer driving an external bank of toggle flip-flops as a clearable,
// loadable up/down counter that stops at a programmable limit.
module tff_bank_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             r,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             cmd_ready,
   input  logic             up,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] t_out,
   output logic             tff_clr,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_e;
   typedef enum logic [1:0] {OP_CLEAR, OP_LOAD, OP_RUN, OP_STOP} op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             clr_q;
   logic [WIDTH-1:0] inc_t, dec_t;
   logic             accept;

   // Ripple-carry toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      logic up_c, dn_c;
      up_c = 1'b1;
      dn_c = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         inc_t[i] = up_c;
         dec_t[i] = dn_c;
         up_c     = up_c & q_in[i];
         dn_c     = dn_c & ~q_in[i];
      end
   end

   assign cmd_ready = r & ((state_q == IDLE) | (state_q == RUN));
   assign accept    = cmd_valid & cmd_ready;
   assign busy      = (state_q != IDLE);
   assign tff_clr   = clr_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      t_out   = '0;
      tc      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_CLEAR: state_d = CLEAR;
                  OP_LOAD: begin
                     data_d  = cmd_data;
                     state_d = LOAD;
                  end
                  OP_RUN:  state_d = RUN;
                  default: state_d = IDLE;
               endcase
            end
         end
         CLEAR: state_d = IDLE;
         LOAD: begin
            t_out   = q_in ^ data_q;
            state_d = IDLE;
         end
         RUN: begin
            if (q_in == limit) begin
               tc      = 1'b1;
               state_d = (accept && cmd_op == OP_CLEAR) ? CLEAR : IDLE;
            end else if (accept && cmd_op == OP_STOP) begin
               state_d = IDLE;
            end else begin
               t_out = up ? inc_t : dec_t;
               if (accept && cmd_op == OP_CLEAR) state_d = CLEAR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q <= IDLE;
         data_q  <= '0;
         clr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         clr_q   <= (state_d == CLEAR);
      end
   end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Bench for tff_bank_ctrl: emulated TFF bank, arithmetic counter model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tff_bank_ctrl;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         r = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic         cmd_ready;
   logic         up = 1'b1;
   logic [W-1:0] limit = 4'hF;
   logic [W-1:0] q_in;
   logic [W-1:0] t_out;
   logic         tff_clr;
   logic         busy;
   logic         tc;

   logic [W-1:0] bank = '0;
   assign q_in = bank;

   int tests = 0;
   int fails = 0;

   tff_bank_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .r(r), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_ready(cmd_ready), .up(up), .limit(limit),
      .q_in(q_in), .t_out(t_out), .tff_clr(tff_clr), .busy(busy), .tc(tc)
   );

   always #5 clk = ~clk;

   // The external flip-flop bank
   always @(posedge clk or posedge tff_clr) begin
      if (tff_clr) bank <= '0;
      else         bank <= bank ^ t_out;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 clear, 2 load, 3 run; cnt is what the bank must hold
   int m_mode = 0, m_cnt = 0, m_data = 0, m_pend = 1;
   int n_mode = 0, n_cnt = 0, n_data = 0, n_pend = 1;

   always @(posedge clk) begin
      m_mode <= n_mode;
      m_cnt  <= n_cnt;
      m_data <= n_data;
      m_pend <= n_pend;
   end

   always @(negedge clk) begin
      int e_t, e_tc, e_ready, e_busy, e_clr;
      bit acc;
      if (!r) begin
         e_t = 0; e_tc = 0; e_ready = 0; e_busy = 0; e_clr = 1;
         n_mode = 0; n_cnt = 0; n_data = 0; n_pend = 1;
         chk("q_in_rst", q_in, 0);
      end else begin
         e_t = 0; e_tc = 0;
         n_mode = 0; n_cnt = m_cnt; n_data = m_data; n_pend = 0;
         e_ready = (m_mode == 0 || m_mode == 3) ? 1 : 0;
         e_busy  = (m_mode != 0) ? 1 : 0;
         e_clr   = (m_pend != 0 || m_mode == 1) ? 1 : 0;
         acc     = cmd_valid && (e_ready != 0);
         case (m_mode)
            0: if (acc) begin
                  if (cmd_op == 2'd0) n_mode = 1;
                  else if (cmd_op == 2'd1) begin n_mode = 2; n_data = int'(cmd_data); end
                  else if (cmd_op == 2'd2) n_mode = 3;
               end
            2: begin e_t = m_cnt ^ m_data; n_cnt = m_data; end
            3: begin
                  if (m_cnt == int'(limit)) begin
                     e_tc = 1;
                     n_mode = (acc && cmd_op == 2'd0) ? 1 : 0;
                  end else if (acc && cmd_op == 2'd3) begin
                     n_mode = 0;
                  end else begin
                     n_cnt  = up ? ((m_cnt + 1) & MASK) : ((m_cnt + MASK) & MASK);
                     e_t    = n_cnt ^ m_cnt;
                     n_mode = (acc && cmd_op == 2'd0) ? 1 : 3;
                  end
               end
            default: ;
         endcase
         if (n_mode == 1) n_cnt = 0;
         chk("q_in", q_in, m_cnt);
      end
      chk("t_out", t_out, e_t);
      chk("tc", tc, e_tc);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("tff_clr", tff_clr, e_clr);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [W-1:0] d);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] v);
      cmd(2'd1, v);
      step();
   endtask

   task automatic wait_q(input logic [W-1:0] v);
      int n;
      n = 0;
      while (q_in !== v && n < 40) begin step(); n++; end
      if (q_in !== v) begin
         tests++; fails++;
         $display("FAIL wait_q: timeout, got %0h expected %0h", q_in, v);
      end
   endtask

   logic [W-1:0] seq3 [4] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110};
   logic [W-1:0] seq4 [4] = '{4'b0001, 4'b0000, 4'b1111, 4'b1110};
   logic         tcs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      #1 r = 1'b0;
      // 1: reset
      repeat (3) step();
      chk("rst_clr", tff_clr, 1);
      chk("rst_t", t_out, 0);
      r = 1'b1;
      #1 chk("clr_after_rise", tff_clr, 1);
      @(posedge clk); #1;
      chk("clr_dropped", tff_clr, 0);
      chk("ready_idle", cmd_ready, 1);
      chk("q_zero", q_in, 0);
      // 2: LOAD 1010
      cmd(2'd1, 4'b1010);
      chk("load_t", t_out, 4'b1010);
      chk("load_busy", busy, 1);
      chk("load_ready", cmd_ready, 0);
      step();
      chk("load_q", q_in, 4'b1010);
      chk("load_busy_end", busy, 0);
      // 3: count up 0011 -> 0110
      load(4'b0011);
      up = 1'b1; limit = 4'b0110;
      cmd(2'd2, '0);
      for (int k = 0; k < 4; k++) begin
         chk("up_seq", q_in, seq3[k]);
         chk("up_tc", tc, tcs[k]);
         step();
      end
      chk("up_done_busy", busy, 0);
      chk("up_done_t", t_out, 0);
      // 4: count down with wrap
      load(4'b0001);
      up = 1'b0; limit = 4'b1110;
      cmd(2'd2, '0);
      for (int k = 0; k < 4; k++) begin
         chk("dn_seq", q_in, seq4[k]);
         chk("dn_tc", tc, tcs[k]);
         step();
      end
      chk("dn_done_busy", busy, 0);
      // 5: STOP and resume
      load(4'b0000);
      up = 1'b1; limit = 4'b1111;
      cmd(2'd2, '0);
      wait_q(4'b0101);
      cmd(2'd3, '0);
      chk("stop_q", q_in, 4'b0101);
      chk("stop_busy", busy, 0);
      step(); step();
      chk("stop_hold", q_in, 4'b0101);
      cmd(2'd2, '0);
      chk("resume_q", q_in, 4'b0101);
      step();
      chk("resume_next", q_in, 4'b0110);
      cmd(2'd3, '0);
      chk("stop2_q", q_in, 4'b0110);
      // start on the limit: immediate tc, no toggles
      load(4'b0111);
      limit = 4'b0111;
      cmd(2'd2, '0);
      chk("at_lim_tc", tc, 1);
      chk("at_lim_t", t_out, 0);
      step();
      chk("at_lim_idle", busy, 0);
      // 6: terminal count with simultaneous CLEAR
      load(4'b0010);
      limit = 4'b0100;
      cmd(2'd2, '0);
      wait_q(4'b0100);
      chk("tc_clr_tc", tc, 1);
      cmd(2'd0, '0);
      chk("tc_clr_clr", tff_clr, 1);
      chk("tc_clr_q", q_in, 0);
      step();
      chk("tc_clr_drop", tff_clr, 0);
      chk("tc_clr_idle", busy, 0);
      // reset in the middle of RUN
      load(4'b0000);
      limit = 4'b1111;
      cmd(2'd2, '0);
      step(); step();
      r = 1'b0;
      #1;
      chk("mid_rst_t", t_out, 0);
      chk("mid_rst_clr", tff_clr, 1);
      chk("mid_rst_q", q_in, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk); @(posedge clk); #1;
      r = 1'b1;
      step();
      chk("rst2_clr", tff_clr, 0);
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
